// File: rtl/adder_arbiter_if.sv
// Request/response bundle for adder_arbiter: NUM_REQ operand ports plus one tagged result channel.
interface adder_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][31:0] req_a;
  logic [NUM_REQ-1:0][31:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [31:0]              rsp_data;
  logic                     rsp_ovf;
  logic                     busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf, busy
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one 32-bit signed adder across NUM_REQ requesters, tagged response channel.
// Optional: define ADDER_ARB_SAT_EN to saturate the sum on signed overflow.
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input logic            clk,
  input logic            rst,
  adder_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] idx_w;
  logic            grant_vld;
  logic [ID_W-1:0] id;
  logic [31:0]     op_a, op_b;
  logic [31:0]     adder_out;
  logic [31:0]     sum_q;
  logic            ovf;
  int              idx;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = ID_W'(idx);
      if (!grant_vld && bus.req_valid[idx_w]) begin
        grant_vld = 1'b1;
        grant     = idx_w;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && grant_vld && !rst) bus.req_ready[grant] = 1'b1;
  end

  assign bus.busy = (state != IDLE);

  // Shared adder path: purely combinational from the registered operands
  assign adder_out = op_a + op_b;
  assign ovf       = (op_a[31] == op_b[31]) && (adder_out[31] != op_a[31]);

`ifdef ADDER_ARB_SAT_EN
  assign sum_q = ovf ? (op_a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : adder_out;
`else
  assign sum_q = adder_out;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      id            <= '0;
      op_a          <= '0;
      op_b          <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_id    <= '0;
      bus.rsp_ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (grant_vld) begin
          op_a   <= bus.req_a[grant];
          op_b   <= bus.req_b[grant];
          id     <= grant;
          rr_ptr <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
        end
        EXEC: begin
          bus.rsp_data  <= sum_q;
          bus.rsp_id    <= id;
          bus.rsp_ovf   <= ovf;
          bus.rsp_valid <= 1'b1;
        end
        RESP: if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
